// File: rtl/dm_latency_ctrl_pkg.sv
// dm_latency_ctrl_pkg: shared width encodings and FSM state type for the data memory
package dm_latency_ctrl_pkg;
  localparam logic [1:0] memWidth4 = 2'd0;
  localparam logic [1:0] memWidth2 = 2'd1;
  localparam logic [1:0] memWidth1 = 2'd2;
  typedef enum logic [1:0] {dmStateIdle, dmStateWait, dmStateResp} dm_state_e;
endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: byte-lane enables, store merge and extended load for one word access
module dm_lane_align
  import dm_latency_ctrl_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  lane,
  input  logic        extend,
  input  logic [31:0] raw,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] merged,
  output logic [31:0] load
);
  logic [15:0] sel_half;
  logic [7:0]  sel_byte;
  logic [31:0] rep, mask;
  // Lane selection, replication of low store bits, and sign/zero extension
  always_comb begin
    sel_half = lane[1] ? raw[31:16] : raw[15:0];
    sel_byte = raw[{lane, 3'b000} +: 8];
    be = width == memWidth4 ? 4'b1111 :
         width == memWidth2 ? (lane[1] ? 4'b1100 : 4'b0011) :
         width == memWidth1 ? 4'b0001 << lane : 4'b0000;
    rep = width == memWidth4 ? wdata :
          width == memWidth2 ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    merged = (raw & ~mask) | (rep & mask);
    load = width == memWidth4 ? raw :
           width == memWidth2 ? {{16{extend & sel_half[15]}}, sel_half} :
           {{24{extend & sel_byte[7]}}, sel_byte};
  end
endmodule

// File: rtl/dm_latency_ctrl.sv
// dm_latency_ctrl: data memory with valid/ready handshake, fixed access latency and fault reporting
module dm_latency_ctrl
  import dm_latency_ctrl_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          LATENCY     = 2,
  parameter bit          TRACE       = 1
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        ready,
  input  logic        writeEnable,
  input  logic [1:0]  widthCtrl,
  input  logic        extendCtrl,
  input  logic [31:0] address,
  input  logic [31:0] writeDataIn,
  input  logic [31:0] debugPC,
  output logic        respValid,
  output logic [31:0] readData,
  output logic        exception
);
  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT    = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;
  dm_state_e   state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        c_we, c_ext;
  logic [1:0]  c_width;
  logic [31:0] c_addr, c_wdata, c_pc;
  logic        live, s_we, s_ext;
  logic [1:0]  s_width;
  logic [31:0] s_addr, s_wdata, s_pc;
  logic        accept, go_resp, fault, commit;
  logic [31:0] offset, merged, load;
  logic [3:0]  be;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  assign ready     = state != dmStateWait;
  assign respValid = state == dmStateResp;
  assign accept    = req && ready;
  // With LATENCY==1 the access edge is the accept edge, so the live inputs are used
  assign live    = state != dmStateWait;
  assign s_we    = live ? writeEnable : c_we;
  assign s_ext   = live ? extendCtrl : c_ext;
  assign s_width = live ? widthCtrl : c_width;
  assign s_addr  = live ? address : c_addr;
  assign s_wdata = live ? writeDataIn : c_wdata;
  assign s_pc    = live ? debugPC : c_pc;
  assign offset  = s_addr - BASE_ADDR;
  assign idx     = offset[AW+1:2];
  assign go_resp = (state == dmStateWait && cnt == 4'd0) || (accept && LATENCY == 1);
  assign fault   = !(s_width inside {memWidth4, memWidth2, memWidth1}) ||
                   (s_width == memWidth4 && offset[1:0] != 2'd0) ||
                   (s_width == memWidth2 && offset[0]) || offset >= LIMIT;
  assign commit  = go_resp && s_we && !fault && |be;
  dm_lane_align u_align (
    .width(s_width), .lane(offset[1:0]), .extend(s_ext), .raw(mem[idx]),
    .wdata(s_wdata), .be(be), .merged(merged), .load(load)
  );
  // State and latency counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= dmStateIdle;
      cnt <= 4'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // Next state: WAIT counts down, IDLE and RESP both start a new request on accept
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == dmStateWait) begin
      state_n = cnt == 4'd0 ? dmStateResp : dmStateWait;
      cnt_n = cnt == 4'd0 ? cnt : cnt - 4'd1;
    end else if (accept) begin
      state_n = LATENCY == 1 ? dmStateResp : dmStateWait;
      cnt_n = CNT_INIT;
    end else
      state_n = dmStateIdle;
  end
  // Capture the request so the requester may change its inputs after the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      c_we <= writeEnable;
      c_ext <= extendCtrl;
      c_width <= widthCtrl;
      c_addr <= address;
      c_wdata <= writeDataIn;
      c_pc <= debugPC;
    end
  end
  // Array access and response registers, updated on the edge entering RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      readData <= 32'd0;
      exception <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else begin
      readData <= go_resp && !fault ? load : 32'd0;
      exception <= go_resp && fault;
      if (commit) mem[idx] <= merged;
    end
  end
  generate
    if (TRACE) begin : g_trace
`ifndef SYNTHESIS
      // Log each committed store with the aligned address and merged word
      always_ff @(posedge clk) begin
        if (!reset && commit) $display("%d@%h: *%h <= %h", $time, s_pc, {s_addr[31:2], 2'b00}, merged);
      end
`endif
    end
  endgenerate
endmodule

// File: tb/tb_dm_latency_ctrl.sv
// tb_dm_latency_ctrl: randomized and directed checks of dm_latency_ctrl against a behavioural model
module tb_dm_latency_ctrl;
  import dm_latency_ctrl_pkg::*;
  logic clk = 0, rst = 1, rst2 = 0;
  logic [3:0] req = '0, ready, resp, exc;
  logic [31:0] rdata [4];
  logic we = 0, ext = 0;
  logic [1:0] w = memWidth4;
  logic [31:0] addr = 0, wd = 0, pc = 0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mem_m [int];
  always #5 clk = ~clk;
  function automatic int lat_of(input int k);
    return k == 1 ? 1 : k == 2 ? 3 : 2;
  endfunction
  function automatic logic [31:0] base_of(input int k);
    return k == 3 ? 32'h1000 : 32'h0;
  endfunction
  for (genvar g = 0; g < 4; g++) begin : g_dut
    dm_latency_ctrl #(.DEPTH_WORDS(4096), .BASE_ADDR(base_of(g)), .LATENCY(lat_of(g)), .TRACE(0)) u_dut (
      .clk(clk), .reset(rst || (g == 2 && rst2)), .req(req[g]), .ready(ready[g]),
      .writeEnable(we), .widthCtrl(w), .extendCtrl(ext), .address(addr),
      .writeDataIn(wd), .debugPC(pc), .respValid(resp[g]), .readData(rdata[g]), .exception(exc[g])
    );
  end
  function automatic void ref_op(input int k, input logic we_i, input logic [1:0] w_i, input logic ext_i,
                                 input logic [31:0] a_i, input logic [31:0] d_i,
                                 output logic [31:0] rd, output logic ex);
    logic [31:0] off, word, fill;
    int n, start, key;
    off = a_i - base_of(k);
    n = w_i == memWidth4 ? 4 : w_i == memWidth2 ? 2 : 1;
    ex = !(w_i inside {memWidth4, memWidth2, memWidth1}) || off % n != 0 || off >= 32'd16384;
    rd = 0;
    if (ex) return;
    key = k * 4096 + int'(off / 4);
    word = mem_m.exists(key) ? mem_m[key] : 32'd0;
    start = int'(off % 4) / n * n;
    if (we_i) begin
      for (int b = 0; b < n; b++) word[8*(start+b) +: 8] = d_i[8*b +: 8];
      mem_m[key] = word;
    end else begin
      fill = n == 4 ? 32'h0 : ~((32'h1 << (8 * n)) - 1);
      rd = (word >> (8 * start)) & ~fill;
      if (ext_i && n < 4 && rd[8*n-1]) rd = rd | fill;
    end
  endfunction
  task automatic xact(input int k, input logic we_i, input logic [1:0] w_i, input logic ext_i,
                      input logic [31:0] a_i, input logic [31:0] d_i, output int lat, output int busy,
                      output logic [31:0] rd, output logic ex, output logic tail);
    @(negedge clk);
    we = we_i; w = w_i; ext = ext_i; addr = a_i; wd = d_i; pc = $urandom; req[k] = 1;
    @(posedge clk);
    #1;
    req[k] = 0;
    {we, w, ext} = 4'($urandom);
    addr = $urandom; wd = $urandom;
    lat = -1; busy = 0; rd = 0; ex = 0;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (!ready[k]) busy++;
      if (resp[k]) begin
        lat = i; rd = rdata[k]; ex = exc[k];
      end
    end
    @(negedge clk);
    tail = resp[k] | exc[k] | (|rdata[k]);
  endtask
  task automatic op(input int k, input logic we_i, input logic [1:0] w_i, input logic ext_i,
                    input logic [31:0] a_i, input logic [31:0] d_i, output int lat, output int busy,
                    output logic [31:0] rd, output logic ex, output logic tail,
                    output logic [31:0] rd_e, output logic ex_e);
    xact(k, we_i, w_i, ext_i, a_i, d_i, lat, busy, rd, ex, tail);
    ref_op(k, we_i, w_i, ext_i, a_i, d_i, rd_e, ex_e);
  endtask
  task automatic test_reset();
    @(negedge clk);
    n_chk++; if (ready !== 4'hf) begin n_fail++; $display("FAIL reset_ready: got %b want 1111", ready); end
    n_chk++; if (resp !== 4'h0) begin n_fail++; $display("FAIL reset_resp: got %b want 0000", resp); end
    n_chk++; if (exc !== 4'h0) begin n_fail++; $display("FAIL reset_exc: got %b want 0000", exc); end
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (rdata[k] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata%0d: got %h want 0", k, rdata[k]); end
    end
  endtask
  task automatic test_directed();
    int lat, busy; logic [31:0] rd, rd_e; logic ex, ex_e, tail;
    op(0, 1, memWidth4, 0, 32'h10, 32'hDEADBEEF, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL st_latency: got %0d want 1", lat); end
    n_chk++; if (busy !== 1) begin n_fail++; $display("FAIL st_busy: got %0d want 1", busy); end
    n_chk++; if (ex !== 0) begin n_fail++; $display("FAIL st_exc: got %b want 0", ex); end
    n_chk++; if (tail !== 0) begin n_fail++; $display("FAIL st_pulse: response outputs still active after pulse"); end
    op(0, 0, memWidth4, 0, 32'h10, 0, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_word: got %h want deadbeef", rd); end
    op(0, 1, memWidth1, 0, 32'h13, 32'hABCD1280, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (ex !== 0) begin n_fail++; $display("FAIL st_byte_exc: got %b want 0", ex); end
    op(0, 0, memWidth1, 1, 32'h13, 0, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL ld_byte_s: got %h want ffffff80", rd); end
    op(0, 0, memWidth1, 0, 32'h13, 0, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL ld_byte_u: got %h want 00000080", rd); end
    op(0, 0, memWidth4, 0, 32'h10, 0, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (rd !== 32'h80ADBEEF) begin n_fail++; $display("FAIL ld_merged: got %h want 80adbeef", rd); end
    op(0, 0, memWidth2, 1, 32'h12, 0, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (rd !== 32'hFFFF80AD) begin n_fail++; $display("FAIL ld_half_s: got %h want ffff80ad", rd); end
    op(0, 0, memWidth2, 0, 32'h11, 0, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if ({ex, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL ld_half_misalign: got exc=%b data=%h want exc=1 data=0", ex, rd); end
    op(0, 1, memWidth2, 0, 32'h16, 32'h12345678, lat, busy, rd, ex, tail, rd_e, ex_e);
    op(0, 0, memWidth4, 0, 32'h14, 0, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (rd !== 32'h56780000) begin n_fail++; $display("FAIL st_half_hi: got %h want 56780000", rd); end
    op(0, 0, 2'd3, 0, 32'h10, 0, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if ({ex, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL bad_width: got exc=%b data=%h want exc=1 data=0", ex, rd); end
    op(0, 1, memWidth4, 0, 32'h4000, 32'h11223344, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (ex !== 1) begin n_fail++; $display("FAIL st_range: got %b want 1", ex); end
    op(0, 0, memWidth4, 0, 32'h0, 0, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if ({ex, rd} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL word0_kept: got exc=%b data=%h want exc=0 data=0", ex, rd); end
  endtask
  task automatic test_reset_mid();
    int lat, busy, seen; logic [31:0] rd, rd_e; logic ex, ex_e, tail;
    @(negedge clk);
    we = 1; w = memWidth4; ext = 0; addr = 32'h20; wd = 32'h12345678; req[2] = 1;
    @(posedge clk);
    #1;
    req[2] = 0; rst2 = 1;
    @(posedge clk);
    #1;
    rst2 = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp[2]) seen++;
    end
    n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL reset_mid_resp: got %0d pulses want 0", seen); end
    op(2, 0, memWidth4, 0, 32'h20, 0, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_mid_store: got %h want 0", rd); end
  endtask
  task automatic test_lat3();
    int lat, busy; logic [31:0] rd, rd_e; logic ex, ex_e, tail;
    op(2, 1, memWidth4, 0, 32'h8, 32'hCAFEF00D, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL lat3_latency: got %0d want 2", lat); end
    n_chk++; if (busy !== 2) begin n_fail++; $display("FAIL lat3_busy: got %0d want 2", busy); end
    op(2, 0, memWidth4, 0, 32'h8, 0, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lat3_load: got %h want cafef00d", rd); end
    n_chk++; if (tail !== 0) begin n_fail++; $display("FAIL lat3_pulse: response outputs still active after pulse"); end
  endtask
  task automatic test_back_to_back();
    int acc = 0, rv = 0, lat, busy; logic [31:0] rd, rd_e, v; logic ex, ex_e, tail;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      we = 1; w = memWidth4; ext = 0; addr = 32'(4 * i); wd = v; req[1] = 1;
      ref_op(1, 1, memWidth4, 0, 32'(4 * i), v, rd_e, ex_e);
      if (ready[1]) acc++;
      @(negedge clk);
      if (resp[1]) rv++;
    end
    req[1] = 0;
    n_chk++; if (acc !== 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 4", acc); end
    n_chk++; if (rv !== 4) begin n_fail++; $display("FAIL b2b_resp: got %0d want 4", rv); end
    @(negedge clk);
    n_chk++; if (resp[1] !== 0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", resp[1]); end
    for (int i = 0; i < 4; i++) begin
      op(1, 0, memWidth4, 0, 32'(4 * i), 0, lat, busy, rd, ex, tail, rd_e, ex_e);
      n_chk++; if (rd !== rd_e || lat !== 0) begin n_fail++; $display("FAIL b2b_load%0d: got %h lat %0d want %h lat 0", i, rd, lat, rd_e); end
    end
  endtask
  task automatic test_base();
    int lat, busy; logic [31:0] rd, rd_e; logic ex, ex_e, tail;
    op(3, 1, memWidth4, 0, 32'h1004, 32'h0BADF00D, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (ex !== 0) begin n_fail++; $display("FAIL base_store: got exc %b want 0", ex); end
    op(3, 0, memWidth4, 0, 32'h1004, 0, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL base_load: got %h want 0badf00d", rd); end
    op(3, 0, memWidth4, 0, 32'h0FFC, 0, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (ex !== 1) begin n_fail++; $display("FAIL base_wrap: got exc %b want 1", ex); end
    op(3, 1, memWidth1, 0, 32'h4FFF, 32'h5A, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (ex !== 0) begin n_fail++; $display("FAIL base_top: got exc %b want 0", ex); end
    op(3, 0, memWidth1, 0, 32'h5000, 0, lat, busy, rd, ex, tail, rd_e, ex_e);
    n_chk++; if (ex !== 1) begin n_fail++; $display("FAIL base_over: got exc %b want 1", ex); end
  endtask
  task automatic test_random();
    int lat, busy; logic [31:0] rd, rd_e, a; logic ex, ex_e, tail, we_r, ext_r; logic [1:0] w_r;
    for (int i = 0; i < 80; i++) begin
      we_r = 1'($urandom); ext_r = 1'($urandom); w_r = 2'($urandom);
      a = $urandom_range(0, 9) == 0 ? $urandom : 32'($urandom_range(0, 63));
      op(0, we_r, w_r, ext_r, a, $urandom, lat, busy, rd, ex, tail, rd_e, ex_e);
      n_chk++; if (ex !== ex_e || lat !== 1 || tail !== 0) begin n_fail++; $display("FAIL rnd_ctrl%0d: got exc %b lat %0d tail %b want exc %b lat 1 tail 0", i, ex, lat, tail, ex_e); end
      if (!we_r) begin
        n_chk++; if (rd !== rd_e) begin n_fail++; $display("FAIL rnd_load%0d: addr %h width %0d got %h want %h", i, a, w_r, rd, rd_e); end
      end
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_directed();
    test_reset_mid();
    test_lat3();
    test_back_to_back();
    test_base();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
